// File: rtl/matrix_fifo_loader.sv
// Reads MATRIX_COLUMNS_A+1 row words from memory and scatters their elements into
// the per-row matrix-A FIFOs, with the final row going to the single matrix-B FIFO.
module matrix_fifo_loader #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned MATRIX_COLUMNS_A = 8,
    parameter int unsigned BASE_ADDR        = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    output logic [31:0]                            mem_address,
    output logic                                   mem_read,
    input  logic                                   mem_waitrequest,
    input  logic [DATA_WIDTH*MATRIX_COLUMNS_A-1:0] mem_readdata,
    input  logic                                   mem_readdatavalid,
    output logic [DATA_WIDTH-1:0]                  fifo_data,
    output logic [MATRIX_COLUMNS_A-1:0]            wrreq_A,
    input  logic [MATRIX_COLUMNS_A-1:0]            wrfull_A,
    output logic                                   wrreq_B,
    input  logic                                   wrfull_B,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned   CntW    = $clog2(MATRIX_COLUMNS_A + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(MATRIX_COLUMNS_A - 1);
    localparam logic [CntW-1:0] LastRow = CntW'(MATRIX_COLUMNS_A);

    typedef enum logic [2:0] {StIdle, StReq, StWaitData, StPush, StDone} state_e;

    state_e                               state_q;
    logic [CntW-1:0]                      row_q;
    logic [CntW-1:0]                      byte_idx_q;
    logic [DATA_WIDTH*MATRIX_COLUMNS_A-1:0] row_data_q;
    logic [31:0]                          mem_address_q;
    logic                                 mem_read_q;
    logic                                 busy_q;
    logic                                 done_q;
    logic                                 tgt_full;
    logic                                 push;

    // Write strobes are gated by the current full flag, so they cannot be registered.
    always_comb begin
        tgt_full = wrfull_B;
        for (int unsigned i = 0; i < MATRIX_COLUMNS_A; i++) begin
            if (row_q == CntW'(i)) tgt_full = wrfull_A[i];
        end
        push    = (state_q == StPush) && !tgt_full;
        wrreq_A = '0;
        for (int unsigned i = 0; i < MATRIX_COLUMNS_A; i++) begin
            wrreq_A[i] = push && (row_q == CntW'(i));
        end
        wrreq_B   = push && (row_q == LastRow);
        fifo_data = '0;
        if (state_q == StPush) begin
            fifo_data = row_data_q[int'(byte_idx_q) * int'(DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            row_q         <= '0;
            byte_idx_q    <= '0;
            row_data_q    <= '0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        row_q         <= '0;
                        byte_idx_q    <= '0;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= BASE_ADDR;
                        busy_q        <= 1'b1;
                        state_q       <= StReq;
                    end
                end
                StReq: begin
                    if (!mem_waitrequest) begin
                        mem_read_q <= 1'b0;
                        state_q    <= StWaitData;
                    end
                end
                StWaitData: begin
                    if (mem_readdatavalid) begin
                        row_data_q <= mem_readdata;
                        byte_idx_q <= '0;
                        state_q    <= StPush;
                    end
                end
                StPush: begin
                    if (!tgt_full) begin
                        if (byte_idx_q == LastIdx) begin
                            if (row_q == LastRow) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                row_q         <= row_q + CntW'(1);
                                mem_read_q    <= 1'b1;
                                mem_address_q <= BASE_ADDR + 32'(row_q) + 32'd1;
                                state_q       <= StReq;
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + CntW'(1);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_matrix_fifo_loader.sv
// Directed bench for matrix_fifo_loader: 2-cycle-latency memory model, FIFO write log,
// and stall/backpressure/restart/reset scenarios checked against hand-computed values.
module tb_matrix_fifo_loader;

    localparam int DW = 8;
    localparam int N  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [31:0]     mem_address;
    logic            mem_read;
    logic            mem_waitrequest;
    logic [DW*N-1:0] mem_readdata;
    logic            mem_readdatavalid;
    logic [DW-1:0]   fifo_data;
    logic [N-1:0]    wrreq_A;
    logic [N-1:0]    wrfull_A;
    logic            wrreq_B;
    logic            wrfull_B;
    logic            busy;
    logic            done;

    matrix_fifo_loader #(
        .DATA_WIDTH      (DW),
        .MATRIX_COLUMNS_A(N),
        .BASE_ADDR       (0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_waitrequest  (mem_waitrequest),
        .mem_readdata     (mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .fifo_data        (fifo_data),
        .wrreq_A          (wrreq_A),
        .wrfull_A         (wrfull_A),
        .wrreq_B          (wrreq_B),
        .wrfull_B         (wrfull_B),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model and monitors
    logic          stall_en = 1'b0;
    logic          bp_en    = 1'b0;
    int            stall_cnt = 0;
    int            bp_cnt    = 0;
    int            bp_stall  = 0;
    int            acc_total = 0;
    int            acc3      = 0;
    int            rd3_cycles = 0;
    int            done_n    = 0;
    int            oh_bad    = 0;
    int            log_n     = 0;
    int            log_t [1024];
    logic [DW-1:0] log_d [1024];
    int            tgt;
    logic          p1_v = 1'b0;
    logic [31:0]   p1_a = '0;
    logic          rv_q = 1'b0;
    logic [DW*N-1:0] rd_q = '0;

    function automatic logic [DW*N-1:0] row_word(input logic [31:0] a);
        logic [DW*N-1:0] w;
        for (int k = 0; k < N; k++) w[k*DW +: DW] = 8'(int'(a) * 8 + k);
        return w;
    endfunction

    assign mem_waitrequest   = stall_en && mem_read && (mem_address == 32'd3) && (stall_cnt < 5);
    assign mem_readdatavalid = rv_q;
    assign mem_readdata      = rd_q;
    assign wrfull_A          = {5'b0, (bp_cnt != 0), 2'b0};
    assign wrfull_B          = 1'b0;

    always @(posedge clk) begin
        p1_v <= mem_read && !mem_waitrequest;
        p1_a <= mem_address;
        rv_q <= p1_v;
        rd_q <= row_word(p1_a);
        if (mem_read && !mem_waitrequest) begin
            acc_total <= acc_total + 1;
            if (mem_address == 32'd3) acc3 <= acc3 + 1;
        end
        if (mem_read && mem_address == 32'd3) rd3_cycles <= rd3_cycles + 1;
        if (mem_waitrequest) stall_cnt <= stall_cnt + 1;
        if (done) done_n <= done_n + 1;
        if (bp_cnt != 0) bp_cnt <= bp_cnt - 1;
        else if (bp_en && wrreq_A[2] && fifo_data == 8'd20) bp_cnt <= 4;
        if (wrfull_A[2] && wrreq_A == '0 && !wrreq_B) bp_stall <= bp_stall + 1;
        if ((wrreq_B || |wrreq_A) && log_n < 1024) begin
            tgt = 8;
            for (int i = 0; i < N; i++) if (wrreq_A[i]) tgt = i;
            log_t[log_n] <= tgt;
            log_d[log_n] <= fifo_data;
            log_n        <= log_n + 1;
        end
    end

    always @(negedge clk) begin
        if (!$onehot0({wrreq_B, wrreq_A}) || (wrreq_A & wrfull_A) != '0 || (wrreq_B && wrfull_B))
            oh_bad <= oh_bad + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_load(input string tag, input int base);
        int bad = 0;
        for (int k = 0; k < 72; k++) begin
            if (log_t[base+k] !== k / 8 || log_d[base+k] !== 8'(k)) bad++;
        end
        chk({tag, " write count"}, 64'(log_n - base), 64'd72);
        chk({tag, " order/data bad entries"}, 64'(bad), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done within bound"}, 64'(n < 3000), 64'd1);
    endtask

    int base, a0, d0, r0, c0, s0, n0;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset mem_read", 64'(mem_read), 64'd0);
        chk("reset mem_address", 64'(mem_address), 64'd0);
        chk("reset wrreq_A", 64'(wrreq_A), 64'd0);
        chk("reset wrreq_B", 64'(wrreq_B), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset fifo_data", 64'(fifo_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal load
        base = log_n; a0 = acc_total; d0 = done_n;
        pulse_start();
        chk("nominal busy after start", 64'(busy), 64'd1);
        chk("nominal first mem_read", 64'(mem_read), 64'd1);
        chk("nominal first address", 64'(mem_address), 64'd0);
        wait_done("nominal");
        @(negedge clk);
        chk("nominal busy after done", 64'(busy), 64'd0);
        chk("nominal done one cycle", 64'(done), 64'd0);
        chk("nominal done pulses", 64'(done_n - d0), 64'd1);
        chk("nominal read requests", 64'(acc_total - a0), 64'd9);
        check_load("nominal", base);

        // Waitrequest stall on row 3
        stall_en = 1'b1;
        base = log_n; a0 = acc_total; r0 = rd3_cycles; c0 = acc3;
        pulse_start();
        wait_done("waitreq");
        @(negedge clk);
        stall_en = 1'b0;
        chk("waitreq row3 read cycles", 64'(rd3_cycles - r0), 64'd6);
        chk("waitreq row3 accepted", 64'(acc3 - c0), 64'd1);
        chk("waitreq read requests", 64'(acc_total - a0), 64'd9);
        check_load("waitreq", base);

        // Backpressure on FIFO A[2] at element 5
        bp_en = 1'b1;
        base = log_n; s0 = bp_stall;
        pulse_start();
        wait_done("backpressure");
        @(negedge clk);
        bp_en = 1'b0;
        chk("backpressure stall cycles", 64'(bp_stall - s0), 64'd4);
        check_load("backpressure", base);

        // start while busy and while in DONE is ignored
        base = log_n; d0 = done_n; a0 = acc_total;
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        wait_done("restart");
        pulse_start();
        repeat (10) @(negedge clk);
        chk("restart busy stays low", 64'(busy), 64'd0);
        chk("restart done pulses", 64'(done_n - d0), 64'd1);
        chk("restart read requests", 64'(acc_total - a0), 64'd9);
        check_load("restart", base);

        // Reset during row 4 PUSH
        pulse_start();
        n0 = 0;
        while (wrreq_A[4] !== 1'b1 && n0 < 2000) begin
            @(negedge clk);
            n0++;
        end
        chk("midreset reached row 4", 64'(n0 < 2000), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset outputs zero",
            64'({mem_read, wrreq_A, wrreq_B, busy, done, mem_address, fifo_data}), 64'd0);
        n0 = log_n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midreset no writes after reset", 64'(log_n - n0), 64'd0);
        chk("midreset busy low", 64'(busy), 64'd0);
        base = log_n;
        pulse_start();
        chk("reload first address", 64'(mem_address), 64'd0);
        chk("reload mem_read", 64'(mem_read), 64'd1);
        wait_done("reload");
        @(negedge clk);
        check_load("reload", base);

        chk("one-hot write requests throughout", 64'(oh_bad), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_fifo_loader.md
MATRIX_FIFO_LOADER -- requirements
Module: matrix_fifo_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the element width in bits.
REQ-002 The block SHALL have parameter MATRIX_COLUMNS_A, default 8, giving the number of matrix-A FIFOs (rows) and the elements per row.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, giving the word address of row 0.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, a load request that is sampled only in IDLE.
REQ-007 The block SHALL have port mem_address, output, 32 bits, the word address of the memory read.
REQ-008 The block SHALL have port mem_read, output, 1 bit, the memory read request.
REQ-009 The block SHALL have port mem_waitrequest, input, 1 bit, indicating the memory is stalling the request.
REQ-010 The block SHALL have port mem_readdata, input, DATA_WIDTH*MATRIX_COLUMNS_A bits, the returned row word.
REQ-011 The block SHALL have port mem_readdatavalid, input, 1 bit, qualifying mem_readdata.
REQ-012 The block SHALL have port fifo_data, output, DATA_WIDTH bits, a write data bus shared by all FIFOs.
REQ-013 The block SHALL have port wrreq_A, output, MATRIX_COLUMNS_A bits, per-FIFO write requests for matrix A.
REQ-014 The block SHALL have port wrfull_A, input, MATRIX_COLUMNS_A bits, per-FIFO full flags for matrix A.
REQ-015 The block SHALL have port wrreq_B, output, 1 bit, the write request for the matrix-B FIFO.
REQ-016 The block SHALL have port wrfull_B, input, 1 bit, the full flag for the matrix-B FIFO.
REQ-017 The block SHALL have port busy, output, 1 bit, high while a load is in progress.
REQ-018 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-019 The block SHALL implement the states IDLE, REQ, WAIT_DATA, PUSH and DONE.
REQ-020 In IDLE, when start=1, the block SHALL clear the row counter and byte counter and go to REQ on the next edge; busy SHALL be high from that cycle on.
REQ-021 In REQ, the block SHALL hold mem_read=1 with mem_address=BASE_ADDR+row and keep both stable while mem_waitrequest=1.
REQ-022 In REQ, the request SHALL complete on the first cycle with mem_waitrequest=0, after which the block goes to WAIT_DATA with mem_read=0.
REQ-023 In WAIT_DATA, on mem_readdatavalid=1 the block SHALL capture mem_readdata into a row register, clear the byte index and go to PUSH; mem_readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-024 In PUSH, fifo_data SHALL be element[byte_idx] of the row register, where element 0 = bits DATA_WIDTH-1:0 and is written first.
REQ-025 In PUSH, target = wrreq_A[row] for row<MATRIX_COLUMNS_A, and target = wrreq_B for row==MATRIX_COLUMNS_A.
REQ-026 The target write request SHALL be asserted only when its full flag is 0; every write request is a single-cycle write that counts as accepted.
REQ-027 At most one of wrreq_A/wrreq_B SHALL be high in any cycle, and none SHALL be high outside PUSH.
REQ-028 While the target full flag is 1, the block SHALL hold byte_idx with the write request low (stall, no data loss).
REQ-029 On the accepted write of element MATRIX_COLUMNS_A-1, the block SHALL go to DONE if row==MATRIX_COLUMNS_A; otherwise it SHALL increment row and go to REQ.
REQ-030 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE with busy=0.
REQ-031 start SHALL be ignored in all states except IDLE, including DONE.
REQ-032 A full load SHALL write MATRIX_COLUMNS_A+1 rows of MATRIX_COLUMNS_A elements each, i.e. 72 writes at defaults.
REQ-033 Minimum latency per row SHALL be 1 REQ cycle + memory latency + 8 PUSH cycles.
REQ-034 The counters SHALL be sized to hold 0..MATRIX_COLUMNS_A without wrap; row SHALL never exceed MATRIX_COLUMNS_A.

Reset
REQ-035 rst_n=0 SHALL asynchronously force the state to IDLE; mem_read, wrreq_A, wrreq_B, busy and done SHALL be 0; mem_address, fifo_data, row and byte_idx SHALL be 0.
REQ-036 A reset in mid-load SHALL abandon the load without further FIFO writes; a later start SHALL begin at row 0.

Verification
REQ-037 Nominal: BASE_ADDR=0, memory rows r hold bytes {r*8+7..r*8}, zero wait, 2-cycle read latency; pulse start -> FIFO A[i] receives i*8..i*8+7 in order, FIFO B receives 64..71, done pulses once, busy is low the next cycle.
REQ-038 Waitrequest: hold mem_waitrequest=1 for 5 cycles on row 3 -> mem_address=3 and mem_read stay stable for 6 cycles and no request is duplicated.
REQ-039 Backpressure: hold wrfull_A[2]=1 for 4 cycles while element 5 is pending -> wrreq_A=0 for 4 cycles, then element 5 is written exactly once and no element is skipped.
REQ-040 start during busy and during DONE -> no restart and the write count stays 72.
REQ-041 Assert rst_n=0 during row 4 PUSH -> all outputs are 0 immediately; after release and start, row 0 is reloaded from address 0.
REQ-042 Assertion throughout: the OR of wrreq_A and wrreq_B is one-hot-or-zero every cycle.
